dram_lsu: RTL and testbench
===========================

DRAM_LSU -- requirements
Module: dram_lsu

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 13, RAM word-address width; the byte window is 2^(ADDR_WIDTH+2) bytes.
REQ-002 SHALL have port clk  input  1  single clock; all logic is on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port req_valid  input  1  CPU load/store request present.
REQ-005 SHALL have port req_ready  output  1  request accepted when req_valid and req_ready are both high at a rising edge.
REQ-006 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-007 SHALL have port req_addr  input  32  byte address.
REQ-008 SHALL have port req_size  input  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-009 SHALL have port req_unsigned  input  1  load zero-extend when 1, sign-extend when 0.
REQ-010 SHALL have port req_wdata  input  32  store data, right-aligned.
REQ-011 SHALL have port rsp_valid  output  1  one-cycle response pulse.
REQ-012 SHALL have port rsp_rdata  output  32  load result, or 0 for store/error.
REQ-013 SHALL have port rsp_err  output  1  misaligned or illegal-size request.
REQ-014 SHALL have ports ram_addr (out, ADDR_WIDTH), ram_wr_data (out, 32), ram_wr_en (out, 1), ram_wr_byte_en (out, 4) and ram_rd_data (in, 32), which drive a single-port RAM with 1-cycle read latency and no output register.

Function
REQ-015 SHALL implement the FSM states IDLE, ISSUE, WAIT and RESP; req_ready is high only in IDLE.
REQ-016 IDLE, on accept: SHALL register the request fields and go to ISSUE, or go to RESP with rsp_err=1 if the request is misaligned or has an illegal size.
REQ-017 Misalignment: half with addr[0]=1; word with addr[1:0]!=0; size 11 is always an error; an error performs no RAM access.
REQ-018 ISSUE: SHALL register ram_addr=addr[ADDR_WIDTH+1:2]; ram_wr_en=we, held high for exactly this one cycle; next state is RESP for a store and WAIT for a load.
REQ-019 Byte enables in ISSUE for a store: byte 0001<<addr[1:0]; half 0011<<addr[1:0]; word 1111; for a load, ram_wr_byte_en=0000.
REQ-020 ram_wr_data in ISSUE: byte {4{wdata[7:0]}}; half {2{wdata[15:0]}}; word wdata.
REQ-021 WAIT: SHALL select the lane of ram_rd_data by addr[1:0] (byte) or addr[1] (half), extend it per req_unsigned, and register the result into rsp_rdata.
REQ-022 RESP: rsp_valid=1 for exactly one cycle, then IDLE; rsp_rdata and rsp_err hold until the next RESP.
REQ-023 Latency from the accept edge to rsp_valid: store 2 cycles, load 3 cycles, error 1 cycle.
REQ-024 Outside ISSUE: ram_wr_en=0 and ram_wr_byte_en=0; ram_addr and ram_wr_data hold their last values.
REQ-025 req_addr[31:ADDR_WIDTH+2] SHALL be ignored, so addresses wrap modulo the window.
REQ-026 There is no response back-pressure; a request offered while not in IDLE SHALL wait, without loss, until req_ready.

Reset
REQ-027 A rising edge with rst_n low SHALL force IDLE and zero req_ready, rsp_valid, rsp_rdata, rsp_err, ram_addr, ram_wr_data, ram_wr_en and ram_wr_byte_en; req_ready rises the cycle after rst_n releases.
REQ-028 Reset mid-operation: a write already driven in ISSUE completes at that edge; the pending response SHALL be discarded and no rsp_valid emitted.

Configuration
REQ-029 With macro DRAM_LSU_MISALIGN_TRAP_EN defined, REQ-016/017 SHALL apply.
REQ-030 Without DRAM_LSU_MISALIGN_TRAP_EN: misaligned half/word accesses SHALL be forced aligned by clearing the offending low address bits, size 11 SHALL be treated as word, and rsp_err SHALL be tied to 0.

Verification
REQ-031 Store word 0xDEADBEEF to 0x0000_0010 -> one cycle later: ram_addr=4, ram_wr_en=1, be=1111; rsp_valid at T+2, rsp_rdata=0.
REQ-032 Store byte 0x5A to 0x13, then load signed byte from 0x13 -> be=1000, wr_data=0x5A5A5A5A; load rsp_rdata=0x0000005A at T+3.
REQ-033 With RAM word 0x80F0_0000, load half signed/unsigned at 0x2 -> rsp_rdata=0xFFFF80F0 / 0x000080F0.
REQ-034 Load word at 0x6 with the macro defined -> rsp_valid and rsp_err at T+1, ram_wr_en stays 0; with the macro undefined -> load from word address 1, rsp_err=0.
REQ-035 Address 0x0000_8004 with ADDR_WIDTH=13 -> ram_addr=1 (wrap).
REQ-036 rst_n low during WAIT -> no rsp_valid, all outputs 0, req_ready=1 one cycle after release.

Source files
------------

// File: rtl/dram_lsu.sv
`default_nettype none
// =============================================================================
// dram_lsu : CPU load/store unit driving a 1-cycle-latency single-port RAM.
// Option   : DRAM_LSU_MISALIGN_TRAP_EN (trap misaligned/illegal instead of aligning)
// Revision : 1.0
// =============================================================================
module dram_lsu #(
  parameter int ADDR_WIDTH = 13
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [31:0]           req_addr,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [31:0]           ram_wr_data,
  output logic                  ram_wr_en,
  output logic [3:0]            ram_wr_byte_en,
  input  logic [31:0]           ram_rd_data
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [1:0] c_sz_byte = 2'b00;
  localparam logic [1:0] c_sz_half = 2'b01;
  localparam logic [1:0] c_sz_word = 2'b10;

  state_t                  state_q;
  logic                    req_ready_q;
  logic                    rsp_valid_q;
  logic [31:0]             rsp_rdata_q;
  logic                    rsp_err_q;
  logic [ADDR_WIDTH-1:0]   ram_addr_q;
  logic [31:0]             ram_wr_data_q;
  logic                    ram_wr_en_q;
  logic [3:0]              ram_wr_byte_en_q;
  logic                    we_q;
  logic [1:0]              size_q;
  logic [1:0]              off_q;
  logic                    uns_q;

  logic [1:0]              size_d;
  logic [1:0]              off_d;
  logic                    err_d;
  logic [3:0]              be_d;
  logic [31:0]             wdata_d;
  logic [31:0]             lane_sh_d;
  logic [31:0]             load_d;

  // Bits above the byte window are deliberately ignored (addresses wrap).
  logic                    unused_addr_hi;
  assign unused_addr_hi = ^req_addr[31:ADDR_WIDTH+2];

  always_comb begin
    size_d = req_size;
    off_d  = req_addr[1:0];
    err_d  = 1'b0;
`ifdef DRAM_LSU_MISALIGN_TRAP_EN
    case (req_size)
      c_sz_half: err_d = req_addr[0];
      c_sz_word: err_d = |req_addr[1:0];
      2'b11:     err_d = 1'b1;
      default:   err_d = 1'b0;
    endcase
`else
    case (req_size)
      c_sz_byte: size_d = c_sz_byte;
      c_sz_half: off_d[0] = 1'b0;
      default: begin
        size_d = c_sz_word;
        off_d  = 2'b00;
      end
    endcase
`endif
    case (size_d)
      c_sz_byte: begin
        be_d    = 4'b0001 << off_d;
        wdata_d = {4{req_wdata[7:0]}};
      end
      c_sz_half: begin
        be_d    = 4'b0011 << off_d;
        wdata_d = {2{req_wdata[15:0]}};
      end
      default: begin
        be_d    = 4'b1111;
        wdata_d = req_wdata;
      end
    endcase
  end

  // Halves are always 2-byte aligned here, so one shift serves both lane selects.
  always_comb begin
    lane_sh_d = ram_rd_data >> {off_q, 3'b000};
    case (size_q)
      c_sz_byte: load_d = uns_q ? {24'd0, lane_sh_d[7:0]}
                                : {{24{lane_sh_d[7]}}, lane_sh_d[7:0]};
      c_sz_half: load_d = uns_q ? {16'd0, lane_sh_d[15:0]}
                                : {{16{lane_sh_d[15]}}, lane_sh_d[15:0]};
      default:   load_d = ram_rd_data;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q          <= IDLE;
      req_ready_q      <= 1'b0;
      rsp_valid_q      <= 1'b0;
      rsp_rdata_q      <= '0;
      rsp_err_q        <= 1'b0;
      ram_addr_q       <= '0;
      ram_wr_data_q    <= '0;
      ram_wr_en_q      <= 1'b0;
      ram_wr_byte_en_q <= 4'b0000;
      we_q             <= 1'b0;
      size_q           <= 2'b00;
      off_q            <= 2'b00;
      uns_q            <= 1'b0;
    end else begin
      ram_wr_en_q      <= 1'b0;
      ram_wr_byte_en_q <= 4'b0000;
      rsp_valid_q      <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_valid && req_ready_q) begin
            req_ready_q <= 1'b0;
            we_q        <= req_we;
            size_q      <= size_d;
            off_q       <= off_d;
            uns_q       <= req_unsigned;
            if (err_d) begin
              state_q     <= RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_rdata_q <= '0;
            end else begin
              // RAM strobes are loaded on entry so they are live for the whole ISSUE cycle.
              state_q          <= ISSUE;
              ram_addr_q       <= req_addr[ADDR_WIDTH+1:2];
              ram_wr_data_q    <= wdata_d;
              ram_wr_en_q      <= req_we;
              ram_wr_byte_en_q <= req_we ? be_d : 4'b0000;
            end
          end else begin
            req_ready_q <= 1'b1;
          end
        end
        ISSUE: begin
          if (we_q) begin
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
          end else begin
            state_q <= WAIT;
          end
        end
        WAIT: begin
          state_q     <= RESP;
          rsp_valid_q <= 1'b1;
          rsp_err_q   <= 1'b0;
          rsp_rdata_q <= load_d;
        end
        RESP: begin
          state_q     <= IDLE;
          req_ready_q <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready      = req_ready_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_rdata      = rsp_rdata_q;
  assign rsp_err        = rsp_err_q;
  assign ram_addr       = ram_addr_q;
  assign ram_wr_data    = ram_wr_data_q;
  assign ram_wr_en      = ram_wr_en_q;
  assign ram_wr_byte_en = ram_wr_byte_en_q;

endmodule
`default_nettype wire

// File: tb/tb_dram_lsu.sv
`default_nettype none
// =============================================================================
// tb_dram_lsu : self-checking bench for dram_lsu against a byte-array model.
// Revision    : 1.0
// =============================================================================
module tb_dram_lsu;

  localparam int AW  = 13;
  localparam int WIN = 1 << (AW + 2);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [31:0]   req_addr = '0;
  logic [1:0]    req_size = '0;
  logic          req_unsigned = 1'b0;
  logic [31:0]   req_wdata = '0;
  logic          rsp_valid;
  logic [31:0]   rsp_rdata;
  logic          rsp_err;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_wr_data;
  logic          ram_wr_en;
  logic [3:0]    ram_wr_byte_en;
  logic [31:0]   ram_rd_data;

  int checks   = 0;
  int failures = 0;

  logic [31:0] mem  [0:(1<<AW)-1];
  logic [7:0]  rmem [0:WIN-1];

  dram_lsu #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .ram_addr(ram_addr), .ram_wr_data(ram_wr_data), .ram_wr_en(ram_wr_en),
    .ram_wr_byte_en(ram_wr_byte_en), .ram_rd_data(ram_rd_data)
  );

  always #5 clk = ~clk;

  // Single-port RAM: synchronous read, data valid the cycle after the address.
  always @(posedge clk) begin
    if (ram_wr_en)
      for (int b = 0; b < 4; b++)
        if (ram_wr_byte_en[b]) mem[ram_addr][8*b +: 8] <= ram_wr_data[8*b +: 8];
    ram_rd_data <= mem[ram_addr];
  end

  // ---------------- reference model (byte-addressed) ----------------
  function automatic bit ref_err(input logic [31:0] a, input logic [1:0] s);
`ifdef DRAM_LSU_MISALIGN_TRAP_EN
    return (s == 2'b11) || (s == 2'b01 && a[0]) || (s == 2'b10 && a[1:0] != 2'b00);
`else
    return 1'b0;
`endif
  endfunction

  function automatic int ref_n(input logic [1:0] s);
    return (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
  endfunction

  function automatic int ref_base(input logic [31:0] a, input logic [1:0] s);
    int x = int'(a % WIN);
    return x - (x % ref_n(s));
  endfunction

  function automatic void ref_store(input logic [31:0] a, input logic [1:0] s, input logic [31:0] d);
    int b = ref_base(a, s);
    for (int k = 0; k < ref_n(s); k++) rmem[b + k] = d[8*k +: 8];
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] s, input logic u);
    int b = ref_base(a, s);
    int n = ref_n(s);
    logic [63:0] v = '0;
    for (int k = 0; k < n; k++) v = v | (64'(rmem[b + k]) << (8*k));
    if (!u && v >= (64'd1 << (8*n - 1))) v = v - (64'd1 << (8*n));
    return v[31:0];
  endfunction

  // One transaction; returns what was observed, callers decide what is right.
  task automatic drive_req(input logic we, input logic [31:0] addr, input logic [1:0] size,
                           input logic uns, input logic [31:0] wdata,
                           output int lat, output logic [31:0] rdata, output logic err,
                           output int nwr, output logic [3:0] be, output logic [31:0] wd,
                           output logic [AW-1:0] ra, output logic bad);
    int n;
    lat = 0; rdata = '0; err = 1'b0; nwr = 0; be = '0; wd = '0; ra = '0; bad = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_size = size;
    req_unsigned = uns; req_wdata = wdata;
    n = 0;
    while (req_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) begin req_valid = 1'b0; return; end
    @(negedge clk);
    req_valid = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      if (ram_wr_en === 1'b1) begin nwr++; be = ram_wr_byte_en; wd = ram_wr_data; end
      else if (ram_wr_byte_en !== 4'b0000) bad = 1'b1;
      if (k == 1) ra = ram_addr;
      if (rsp_valid === 1'b1) begin lat = k; rdata = rsp_rdata; err = rsp_err; break; end
      @(negedge clk);
    end
    @(negedge clk);
    if (rsp_valid !== 1'b0 || rsp_rdata !== rdata || rsp_err !== err) bad = 1'b1;
  endtask

  int          lat, nwr;
  logic [31:0] rdata, wd;
  logic        err, bad;
  logic [3:0]  be;
  logic [AW-1:0] ra;

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({req_ready, rsp_valid, rsp_rdata, rsp_err, ram_addr, ram_wr_data, ram_wr_en, ram_wr_byte_en} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got ready=%b vld=%b rd=%h err=%b ra=%h wd=%h we=%b be=%b, want all 0",
               req_ready, rsp_valid, rsp_rdata, rsp_err, ram_addr, ram_wr_data, ram_wr_en, ram_wr_byte_en);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_ready_rise got=%b want=1", req_ready); end
  endtask

  task automatic test_directed();
    drive_req(1'b1, 32'h0000_0010, 2'b10, 1'b0, 32'hDEAD_BEEF, lat, rdata, err, nwr, be, wd, ra, bad);
    ref_store(32'h10, 2'b10, 32'hDEAD_BEEF);
    checks++; if (ra !== 13'd4) begin failures++; $display("FAIL stw_addr got=%0d want=4", ra); end
    checks++; if (nwr !== 1 || be !== 4'b1111) begin failures++; $display("FAIL stw_be got n=%0d be=%b want 1/1111", nwr, be); end
    checks++; if (wd !== 32'hDEAD_BEEF) begin failures++; $display("FAIL stw_wdata got=%h want=deadbeef", wd); end
    checks++; if (lat !== 2 || rdata !== 32'd0 || err !== 1'b0 || bad) begin
      failures++; $display("FAIL stw_rsp got lat=%0d rd=%h err=%b bad=%b want 2/0/0/0", lat, rdata, err, bad); end

    drive_req(1'b1, 32'h0000_0013, 2'b00, 1'b0, 32'h1234_565A, lat, rdata, err, nwr, be, wd, ra, bad);
    ref_store(32'h13, 2'b00, 32'h1234_565A);
    checks++; if (be !== 4'b1000 || wd !== 32'h5A5A_5A5A || lat !== 2) begin
      failures++; $display("FAIL stb got be=%b wd=%h lat=%0d want 1000/5a5a5a5a/2", be, wd, lat); end
    drive_req(1'b0, 32'h0000_0013, 2'b00, 1'b0, 32'h0, lat, rdata, err, nwr, be, wd, ra, bad);
    checks++; if (rdata !== 32'h0000_005A || lat !== 3 || nwr !== 0) begin
      failures++; $display("FAIL ldb got rd=%h lat=%0d nwr=%0d want 0000005a/3/0", rdata, lat, nwr); end

    drive_req(1'b1, 32'h0000_0000, 2'b10, 1'b0, 32'h80F0_0000, lat, rdata, err, nwr, be, wd, ra, bad);
    ref_store(32'h0, 2'b10, 32'h80F0_0000);
    drive_req(1'b0, 32'h0000_0002, 2'b01, 1'b0, 32'h0, lat, rdata, err, nwr, be, wd, ra, bad);
    checks++; if (rdata !== 32'hFFFF_80F0) begin failures++; $display("FAIL ldh_signed got=%h want=ffff80f0", rdata); end
    drive_req(1'b0, 32'h0000_0002, 2'b01, 1'b1, 32'h0, lat, rdata, err, nwr, be, wd, ra, bad);
    checks++; if (rdata !== 32'h0000_80F0) begin failures++; $display("FAIL ldh_unsigned got=%h want=000080f0", rdata); end

    drive_req(1'b1, 32'h0000_8004, 2'b10, 1'b0, 32'h1122_3344, lat, rdata, err, nwr, be, wd, ra, bad);
    ref_store(32'h8004, 2'b10, 32'h1122_3344);
    checks++; if (ra !== 13'd1) begin failures++; $display("FAIL wrap_addr got=%0d want=1", ra); end

    drive_req(1'b0, 32'h0000_0006, 2'b10, 1'b0, 32'h0, lat, rdata, err, nwr, be, wd, ra, bad);
`ifdef DRAM_LSU_MISALIGN_TRAP_EN
    checks++; if (lat !== 1 || err !== 1'b1 || nwr !== 0 || rdata !== 32'd0) begin
      failures++; $display("FAIL misalign_trap got lat=%0d err=%b nwr=%0d rd=%h want 1/1/0/0", lat, err, nwr, rdata); end
`else
    checks++; if (lat !== 3 || err !== 1'b0 || ra !== 13'd1 || rdata !== ref_load(32'h6, 2'b10, 1'b0)) begin
      failures++; $display("FAIL misalign_force got lat=%0d err=%b ra=%0d rd=%h want 3/0/1/%h",
                           lat, err, ra, rdata, ref_load(32'h6, 2'b10, 1'b0)); end
`endif
  endtask

  task automatic test_random();
    logic [31:0] a, d, exp_rd;
    logic [1:0]  s;
    logic        w, u, e;
    logic [3:0]  exp_be;
    int          b, n, exp_lat;
    for (int i = 0; i < 16; i++) begin
      a = ($urandom & 32'hFFFF_8000) | (i * 4);
      d = $urandom;
      drive_req(1'b1, a, 2'b10, 1'b0, d, lat, rdata, err, nwr, be, wd, ra, bad);
      ref_store(a, 2'b10, d);
      checks++; if (lat !== 2) begin failures++; $display("FAIL prefill_lat[%0d] got=%0d want=2", i, lat); end
    end
    for (int i = 0; i < 60; i++) begin
      a = ($urandom & 32'hFFFF_8000) | 32'($urandom_range(0, 63));
      s = 2'($urandom_range(0, 3));
      w = 1'($urandom_range(0, 1));
      u = 1'($urandom_range(0, 1));
      d = $urandom;
      e = ref_err(a, s);
      b = ref_base(a, s);
      n = ref_n(s);
      exp_lat = e ? 1 : (w ? 2 : 3);
      exp_rd  = (e || w) ? 32'd0 : ref_load(a, s, u);
      drive_req(w, a, s, u, d, lat, rdata, err, nwr, be, wd, ra, bad);
      checks++;
      if (lat !== exp_lat || err !== e || rdata !== exp_rd || bad) begin
        failures++;
        $display("FAIL rand_rsp[%0d] a=%h s=%0d we=%b got lat=%0d err=%b rd=%h bad=%b want %0d/%b/%h/0",
                 i, a, s, w, lat, err, rdata, bad, exp_lat, e, exp_rd);
      end
      checks++;
      if (nwr !== ((w && !e) ? 1 : 0)) begin
        failures++; $display("FAIL rand_wr_count[%0d] got=%0d want=%0d", i, nwr, (w && !e) ? 1 : 0);
      end
      if (!e) begin
        checks++;
        if (ra !== AW'(b / 4)) begin failures++; $display("FAIL rand_addr[%0d] got=%0d want=%0d", i, ra, b / 4); end
      end
      if (w && !e) begin
        exp_be = '0;
        for (int k = 0; k < n; k++) exp_be[(b % 4) + k] = 1'b1;
        checks++;
        if (be !== exp_be) begin failures++; $display("FAIL rand_be[%0d] got=%b want=%b", i, be, exp_be); end
        for (int k = 0; k < n; k++) begin
          checks++;
          if (wd[8*((b % 4) + k) +: 8] !== d[8*k +: 8]) begin
            failures++; $display("FAIL rand_wlane[%0d.%0d] got=%h want=%h", i, k, wd[8*((b % 4) + k) +: 8], d[8*k +: 8]);
          end
        end
        ref_store(a, s, d);
      end
    end
  endtask

  task automatic test_reset_mid();
    int n;
    // Load aborted while waiting for RAM data.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_size = 2'b10; req_unsigned = 1'b0;
    n = 0;
    while (req_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    @(negedge clk); req_valid = 1'b0;
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({req_ready, rsp_valid, rsp_rdata, rsp_err, ram_addr, ram_wr_data, ram_wr_en, ram_wr_byte_en} !== '0) begin
      failures++; $display("FAIL midrst_wait_outputs got vld=%b rd=%h ra=%h wd=%h ready=%b want all 0",
                           rsp_valid, rsp_rdata, ram_addr, ram_wr_data, req_ready);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      failures++; $display("FAIL midrst_wait_release got ready=%b vld=%b want 1/0", req_ready, rsp_valid);
    end
    // Store whose write strobe is live when reset hits: the write still lands.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h18; req_size = 2'b10; req_wdata = 32'hCAFE_F00D;
    n = 0;
    while (req_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    @(negedge clk); req_valid = 1'b0;
    checks++;
    if (ram_wr_en !== 1'b1) begin failures++; $display("FAIL midrst_issue_we got=%b want=1", ram_wr_en); end
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || ram_wr_en !== 1'b0) begin
      failures++; $display("FAIL midrst_store_rsp got vld=%b we=%b want 0/0", rsp_valid, ram_wr_en);
    end
    rst_n = 1'b1;
    @(negedge clk);
    ref_store(32'h18, 2'b10, 32'hCAFE_F00D);
    drive_req(1'b0, 32'h18, 2'b10, 1'b0, 32'h0, lat, rdata, err, nwr, be, wd, ra, bad);
    checks++;
    if (rdata !== ref_load(32'h18, 2'b10, 1'b0) || lat !== 3) begin
      failures++; $display("FAIL midrst_write_landed got rd=%h lat=%0d want %h/3", rdata, lat, ref_load(32'h18, 2'b10, 1'b0));
    end
  endtask

  task automatic test_back_to_back();
    int n, pulses, busy;
    logic acc;
    logic [31:0] last;
    pulses = 0; busy = 0; last = '0;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h2C; req_size = 2'b10; req_wdata = 32'h0BAD_F00D;
    n = 0;
    while (req_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    ref_store(32'h2C, 2'b10, 32'h0BAD_F00D);
    req_we = 1'b0; req_unsigned = 1'b0;
    for (int k = 0; k < 20; k++) begin
      acc = req_valid && (req_ready === 1'b1);
      if (rsp_valid === 1'b1) begin pulses++; last = rsp_rdata; end
      if (req_valid && req_ready !== 1'b1) busy++;
      @(negedge clk);
      if (acc) req_valid = 1'b0;
    end
    req_valid = 1'b0;
    checks++;
    if (pulses !== 2 || busy !== 2) begin
      failures++; $display("FAIL b2b_handshake got pulses=%0d busy=%0d want 2/2", pulses, busy);
    end
    checks++;
    if (last !== ref_load(32'h2C, 2'b10, 1'b0)) begin
      failures++; $display("FAIL b2b_load_data got=%h want=%h", last, ref_load(32'h2C, 2'b10, 1'b0));
    end
  endtask

  initial begin
    for (int i = 0; i < WIN; i++) rmem[i] = 8'h00;
    test_reset();
    test_directed();
    test_random();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
